rand_inst_mem_model: RTL

Synthesizable instruction-memory model for processor bring-up and random-regression benches. After reset it fills an internal word array with pseudo-random MIPS ALU/branch instructions from an LFSR, inserting a NOP delay slot after each branch. It then serves fetches over the processor's InstMem_Read/InstMem_Ready handshake with a programmable number of wait states. It replaces the hand-built combinational instruction array in benches, and it exercises processor stall paths that a zero-latency memory never reaches.

---
 rtl/rand_inst_mem_model.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/rand_inst_mem_model.sv
// Instruction-memory model: fills a word array with pseudo-random MIPS
// ALU/branch instructions from a Galois LFSR, then serves fetches over the
// InstMem_Read/InstMem_Ready handshake with a fixed number of wait states.
//
// state  | meaning
// -------+--------------------------------------------------------------
// S_FILL | writing one generated word per cycle; fetches are ignored
// S_IDLE | waiting for InstMem_Read; latches word index and misalign flag
// S_WAIT | burning WAIT_STATES cycles before the response
// S_RESP | presents the word with InstMem_Ready for one cycle
module rand_inst_mem_model #(
  parameter int          DATA_WIDTH  = 32,
  parameter int          ADDR_BITS   = 10,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] SEED        = 32'd310,
  parameter bit          BRANCH_EN   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  regen,
  input  logic                  InstMem_Read,
  input  logic [31:0]           inst_address,
  output logic [DATA_WIDTH-1:0] inst_in,
  output logic                  InstMem_Ready,
  output logic                  fill_busy,
  output logic                  addr_err,
  output logic [31:0]           fetch_count
);

  localparam int          DEPTH      = 2 ** ADDR_BITS;
  localparam logic [31:0] LFSR_MASK  = 32'h8020_0003;
  localparam logic [31:0] SEED_EFF   = (SEED == 32'd0) ? 32'd1 : SEED;
  localparam logic [3:0]  WS_LAST    = 4'(WAIT_STATES - 1);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;
  localparam logic [5:0] FN_NOR = 6'h27;

  typedef enum logic [1:0] {S_FILL, S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                r_state;
  logic [ADDR_BITS-1:0]  r_fill_idx;
  logic [ADDR_BITS-1:0]  r_idx;
  logic [31:0]           r_lfsr;
  logic                  r_nop_pend;
  logic                  r_mis;
  logic [3:0]            r_wait_cnt;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic [31:0]           w_lfsr_next;
  logic [5:0]            w_funct;
  logic                  w_is_branch;
  logic                  w_last;
  logic [DATA_WIDTH-1:0] w_fill_word;
  logic                  w_unused_addr;

  // Upper address bits are deliberately ignored so fetches wrap modulo the array size.
  assign w_unused_addr = ^inst_address[31:ADDR_BITS+2];

  assign w_lfsr_next = {1'b0, r_lfsr[31:1]} ^ (r_lfsr[0] ? LFSR_MASK : 32'h0);
  assign w_last      = &r_fill_idx;
  assign w_is_branch = BRANCH_EN && (r_lfsr[31:30] == 2'b11);

  // R-type function select from the low LFSR bits.
  always_comb begin
    w_funct = FN_SUB;
    case (r_lfsr[2:0])
      3'd0:    w_funct = FN_SUB;
      3'd1:    w_funct = FN_ADD;
      3'd2:    w_funct = FN_NOR;
      3'd3:    w_funct = FN_OR;
      3'd4:    w_funct = FN_XOR;
      3'd5:    w_funct = FN_AND;
      3'd6:    w_funct = FN_AND;
      default: w_funct = FN_XOR;
    endcase
  end

  // Word generated for the current fill slot; delay slots and a branch drawn
  // in the final slot (which would have no room for its NOP) become zero.
  always_comb begin
    w_fill_word = '0;
    case (r_lfsr[31:29])
      3'd0:    w_fill_word = {OP_ORI,  r_lfsr[25:0]};
      3'd1:    w_fill_word = {OP_ANDI, r_lfsr[25:0]};
      3'd2:    w_fill_word = {OP_ADDI, r_lfsr[25:0]};
      3'd3:    w_fill_word = {OP_XORI, r_lfsr[25:0]};
      3'd4:    w_fill_word = {OP_LUI,  r_lfsr[25:0]};
      3'd5:    w_fill_word = {OP_RTYPE, r_lfsr[25:11], 5'b0, w_funct};
      3'd6:    w_fill_word = BRANCH_EN ? {OP_BEQ, r_lfsr[25:0]} : {OP_ORI,  r_lfsr[25:0]};
      default: w_fill_word = BRANCH_EN ? {OP_BNE, r_lfsr[25:0]} : {OP_ANDI, r_lfsr[25:0]};
    endcase
    if (r_nop_pend || (w_is_branch && w_last)) begin
      w_fill_word = '0;
    end
  end

  // Array write port, active only while filling; no reset so it maps to RAM.
  always_ff @(posedge clk) begin
    if (r_state == S_FILL) begin
      r_mem[r_fill_idx] <= w_fill_word;
    end
  end

  // Control FSM with registered outputs; regen is a reset that also restarts the fill.
  always_ff @(posedge clk) begin
    if (rst || regen) begin
      r_state       <= S_FILL;
      r_fill_idx    <= '0;
      r_lfsr        <= SEED_EFF;
      r_nop_pend    <= 1'b0;
      r_idx         <= '0;
      r_mis         <= 1'b0;
      r_wait_cnt    <= '0;
      inst_in       <= '0;
      InstMem_Ready <= 1'b0;
      addr_err      <= 1'b0;
      fetch_count   <= '0;
      fill_busy     <= 1'b1;
    end else begin
      InstMem_Ready <= 1'b0;
      addr_err      <= 1'b0;
      case (r_state)
        S_FILL: begin
          r_lfsr     <= w_lfsr_next;
          r_fill_idx <= r_fill_idx + 1'b1;
          r_nop_pend <= !r_nop_pend && w_is_branch && !w_last;
          if (w_last) begin
            r_state   <= S_IDLE;
            fill_busy <= 1'b0;
          end
        end
        S_IDLE: begin
          if (InstMem_Read) begin
            r_idx      <= inst_address[ADDR_BITS+1:2];
            r_mis      <= |inst_address[1:0];
            r_wait_cnt <= '0;
            r_state    <= (WAIT_STATES == 0) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_wait_cnt == WS_LAST) begin
            r_state <= S_RESP;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        S_RESP: begin
          InstMem_Ready <= 1'b1;
          addr_err      <= r_mis;
          inst_in       <= r_mis ? '0 : r_mem[r_idx];
          fetch_count   <= fetch_count + 32'd1;
          r_state       <= S_IDLE;
        end
        default: r_state <= S_FILL;
      endcase
    end
  end

endmodule
